// File: rtl/lfsr_arbiter.sv
// lfsr_arbiter: round-robin sharing of one LFSR among requesters, with optional
// reseed, a STRIDE-cycle decorrelation wait and all-zero lock-up protection.
module lfsr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int WIDTH   = 8,
   parameter int STRIDE  = 8,
   localparam int IW = $clog2(NUM_REQ),
   localparam int CW = $clog2(STRIDE + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid_i,
   input  logic [NUM_REQ-1:0]       req_load_i,
   input  logic [NUM_REQ*WIDTH-1:0] req_seed_i,
   output logic [NUM_REQ-1:0]       req_ack_o,
   output logic                     rsp_valid_o,
   output logic [IW-1:0]            rsp_id_o,
   output logic [WIDTH-1:0]         rsp_data_o,
   output logic                     rsp_fixup_o,
   output logic                     rsp_lockup_o,
   output logic                     lfsr_we_o,
   output logic [WIDTH-1:0]         lfsr_seed_o,
   input  logic [WIDTH-1:0]         lfsr_bits_i
);
   typedef enum logic [1:0] {IDLE, SEED, RUN, RESP} state_t;
   state_t               state_q, state_d;
   logic [IW-1:0]        ptr_q, ptr_d, gid_q, gid_d, rsp_id_q, rsp_id_d, gnt;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 fix_q, fix_d, found;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic                 rsp_valid_q, rsp_valid_d, rsp_fixup_q, rsp_fixup_d;
   logic                 rsp_lockup_q, rsp_lockup_d, lfsr_we_q, lfsr_we_d;
   logic [WIDTH-1:0]     rsp_data_q, rsp_data_d, lfsr_seed_q, lfsr_seed_d, sel_seed;
   int                   idx;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         gid_q        <= '0;
         cnt_q        <= '0;
         fix_q        <= 1'b0;
         ack_q        <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_data_q   <= '0;
         rsp_fixup_q  <= 1'b0;
         rsp_lockup_q <= 1'b0;
         lfsr_we_q    <= 1'b0;
         lfsr_seed_q  <= '1;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         gid_q        <= gid_d;
         cnt_q        <= cnt_d;
         fix_q        <= fix_d;
         ack_q        <= ack_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_data_q   <= rsp_data_d;
         rsp_fixup_q  <= rsp_fixup_d;
         rsp_lockup_q <= rsp_lockup_d;
         lfsr_we_q    <= lfsr_we_d;
         lfsr_seed_q  <= lfsr_seed_d;
      end
   end
   // Outputs are registered, so each state's outputs are set on the edge entering it.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      gid_d        = gid_q;
      cnt_d        = cnt_q;
      fix_d        = fix_q;
      ack_d        = '0;
      rsp_valid_d  = 1'b0;
      rsp_id_d     = rsp_id_q;
      rsp_data_d   = rsp_data_q;
      rsp_fixup_d  = rsp_fixup_q;
      rsp_lockup_d = rsp_lockup_q;
      lfsr_we_d    = 1'b0;
      lfsr_seed_d  = lfsr_seed_q;
      found        = 1'b0;
      gnt          = '0;
      idx          = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req_valid_i[IW'(idx)]) begin
            found = 1'b1;
            gnt   = IW'(idx);
         end
      end
      sel_seed = req_seed_i[int'(gnt)*WIDTH +: WIDTH];
      case (state_q)
         IDLE: if (found) begin
            gid_d = gnt;
            ptr_d = (gnt == IW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
            cnt_d = '0;
            fix_d = req_load_i[gnt] && (sel_seed == '0);
            state_d = req_load_i[gnt] ? SEED : RUN;
            if (req_load_i[gnt]) begin
               lfsr_we_d   = 1'b1;
               lfsr_seed_d = (sel_seed == '0) ? '1 : sel_seed;
            end
         end
         SEED: begin
            cnt_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CW'(STRIDE)) begin
               state_d        = RESP;
               rsp_valid_d    = 1'b1;
               ack_d[gid_q]   = 1'b1;
               rsp_id_d       = gid_q;
               rsp_data_d     = lfsr_bits_i;
               rsp_fixup_d    = fix_q;
               rsp_lockup_d   = (lfsr_bits_i == '0);
               lfsr_we_d      = (lfsr_bits_i == '0);
               lfsr_seed_d    = (lfsr_bits_i == '0) ? '1 : lfsr_seed_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   assign req_ack_o    = ack_q;
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_id_o     = rsp_id_q;
   assign rsp_data_o   = rsp_data_q;
   assign rsp_fixup_o  = rsp_fixup_q;
   assign rsp_lockup_o = rsp_lockup_q;
   assign lfsr_we_o    = lfsr_we_q;
   assign lfsr_seed_o  = lfsr_seed_q;
endmodule

// File: doc/lfsr_arbiter.md
Name: lfsr_arbiter

Overview:
Round-robin controller that shares one 8-bit LFSR (seed-loadable, free-running shifter) among NUM_REQ requesters. Each granted requester may optionally reseed the LFSR. The controller then waits STRIDE shift cycles so successive handed-out bytes are decorrelated, and returns one random byte tagged with the requester id. It also guards against the all-zero lock-up state, by seed substitution and by recovery reload.

Parameters:
NUM_REQ, 2, number of requesters (>=2)
WIDTH, 8, LFSR width in bits
STRIDE, 8, LFSR shift cycles between grant and sample (>=1)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
req_valid  input  NUM_REQ  per-requester request; held until matching req_ack bit
req_load  input  NUM_REQ  per-requester: reseed LFSR before sampling
req_seed  input  NUM_REQ*WIDTH  per-requester seed, requester i at [i*WIDTH +: WIDTH]
req_ack  output  NUM_REQ  one-hot, one-cycle pulse on completion
rsp_valid  output  1  one-cycle pulse; response fields valid
rsp_id  output  clog2(NUM_REQ)  index of served requester
rsp_data  output  WIDTH  sampled LFSR value
rsp_fixup  output  1  requested seed was zero and was replaced
rsp_lockup  output  1  sampled value was all-zero; recovery reload issued
lfsr_we  output  1  to LFSR write_enable
lfsr_seed  output  WIDTH  to LFSR seed
lfsr_bits  input  WIDTH  from LFSR state

Behaviour:
- Reset (rst_n low at posedge): state IDLE; rr pointer=0; counter=0.
- Reset values: req_ack=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_fixup=0, rsp_lockup=0, lfsr_we=0, lfsr_seed=all-ones.
- Reset takes priority over every state. A transaction in flight is abandoned: no ack, no rsp.
- States: IDLE, SEED, RUN, RESP. All outputs are registered.
- IDLE: if any req_valid bit is set, grant the first set bit searching from pointer upward with wrap.
  - Latch grant id, load flag and seed.
  - Set pointer = grant+1 mod NUM_REQ.
  - Next state is SEED if load=1, else RUN.
  - If no request, stay in IDLE.
- SEED (exactly 1 cycle): lfsr_we=1, lfsr_seed=latched seed.
  - A latched seed of 0 is replaced by all-ones and sets the fixup flag.
  - Next state RUN.
- RUN: lfsr_we=0; counter counts 1..STRIDE, one per cycle.
  - On the STRIDE-th cycle, capture lfsr_bits into rsp_data and go to RESP.
- RESP (exactly 1 cycle): rsp_valid=1, req_ack[grant]=1, rsp_id=grant, rsp_fixup=latched flag.
  - rsp_lockup=1 if rsp_data==0. In that case the same cycle also drives lfsr_we=1, lfsr_seed=all-ones.
  - Next state IDLE.
- Response fields hold their last value after rsp_valid drops. req_ack and lfsr_we are pulses.
- Latency without load: request sampled in IDLE cycle 0; RUN occupies cycles 1..STRIDE; rsp_valid in cycle STRIDE+1.
- Latency with load: one cycle longer.
- There is at least one IDLE cycle between transactions.
- req_valid, req_load and req_seed changes after grant are ignored; all are latched at grant.
- A requester that drops req_valid mid-transaction still receives ack/rsp.
- Requests from other requesters arriving while busy are not lost; they are arbitrated at the next IDLE.
- Pointer update guarantees no starvation: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0.
- Counter width is clog2(STRIDE+1). The counter clears on entry to RUN; no wrap occurs inside RUN.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with req_valid=2'b11 -> req_ack=0, rsp_valid=0, lfsr_we=0, lfsr_seed=0xFF; first grant after release is id 0.
- Seeded request, STRIDE=8: req_valid[0]=1, req_load[0]=1, seed 0xA5 at cycle 0.
  - Cycle 1: lfsr_we=1, lfsr_seed=0xA5.
  - Cycle 10: rsp_valid=1, req_ack=2'b01, rsp_id=0, rsp_fixup=0.
  - rsp_data equals lfsr_bits at cycle 9, checked against the LFSR reference model.
- Fairness: req_valid=2'b11 held, no load, for 4 transactions -> rsp_id sequence 0,1,0,1; rsp_valid pulses spaced STRIDE+2=10 cycles apart.
- Zero seed: req_load[1]=1, seed 0x00 -> SEED cycle drives lfsr_seed=0xFF; rsp_id=1, rsp_fixup=1.
- Lock-up: stub lfsr_bits=0x00 with no load -> RESP cycle shows rsp_data=0x00, rsp_lockup=1, lfsr_we=1, lfsr_seed=0xFF.
- Mid-operation reset: assert rst_n=0 during RUN cycle 4 -> no rsp_valid or req_ack afterwards; pointer back to 0; a new request completes normally.
